// File: rtl/twophase_rr_injector_if.sv
// Requester-side valid/ready bundle plus the two-phase bundled-data channel.
// master = requesters and async sink; slave = the injector.
interface twophase_rr_injector_if #(
    parameter int N = 2,
    parameter int W = 8
);
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           req_out;
    logic [W-1:0]   data_out;
    logic           ack_in;

    modport master (
        output in_valid, in_data, ack_in,
        input  in_ready, req_out, data_out
    );

    modport slave (
        input  in_valid, in_data, ack_in,
        output in_ready, req_out, data_out
    );
endinterface

// File: rtl/twophase_rr_injector.sv
// Round-robin arbiter feeding one two-phase bundled-data channel, with a
// watchdog on the ack and a wrapping completed-transaction counter.
module twophase_rr_injector #(
    parameter int N         = 2,
    parameter int W         = 8,
    parameter int SETUP_CYC = 1,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16,
    localparam int GW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst_async,
    input  logic                    enable,
    input  logic                    err_clr,
    twophase_rr_injector_if.slave   bus,
    output logic                    busy,
    output logic [GW-1:0]           grant_id,
    output logic                    timeout_err,
    output logic [CNT_W-1:0]        tx_count
);
    localparam int SW  = $clog2(SETUP_CYC + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, ERR} state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [W-1:0]     data_q, data_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    rr_q, rr_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    sc_q, sc_d;
    logic [WDW-1:0]   wd_q, wd_d;
    logic             ack_s1_q, ack_s_q;

    logic [N-1:0]     ready;
    logic [GW-1:0]    g;
    logic             found;
    logic             acked;
    int               idx;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                g     = GW'(idx);
            end
        end
        ready = '0;
        if (state_q == IDLE && enable && found) ready[g] = 1'b1;
    end

    assign acked = (ack_s_q == req_q);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        sc_d    = sc_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                if (|ready) begin
                    state_d = SETUP;
                    data_d  = bus.in_data[int'(g)*W +: W];
                    grant_d = g;
                    rr_d    = g;
                    sc_d    = SW'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (sc_q == '0) begin
                    req_d   = ~req_q;
                    wd_d    = '0;
                    state_d = WAIT;
                end else begin
                    sc_d = sc_q - 1'b1;
                end
            end
            WAIT: begin
                if (acked) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end else if (wd_q == WDW'(TIMEOUT)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ERR: begin
                if (err_clr) begin
                    err_d   = 1'b0;
                    wd_d    = '0;
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            data_q   <= '0;
            grant_q  <= '0;
            rr_q     <= GW'(N - 1);
            err_q    <= 1'b0;
            cnt_q    <= '0;
            sc_q     <= '0;
            wd_q     <= '0;
            ack_s1_q <= 1'b0;
            ack_s_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            data_q   <= data_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            sc_q     <= sc_d;
            wd_q     <= wd_d;
            ack_s1_q <= bus.ack_in;
            ack_s_q  <= ack_s1_q;
        end
    end

    assign bus.in_ready = ready;
    assign bus.req_out  = req_q;
    assign bus.data_out = data_q;
    assign busy         = (state_q != IDLE);
    assign grant_id     = grant_q;
    assign timeout_err  = err_q;
    assign tx_count     = cnt_q;
endmodule

// File: tb/tb_twophase_rr_injector.sv
// Randomized bench for twophase_rr_injector against a transaction-level
// model: rotating-priority pick, expected data, latencies and counter.
module tb_twophase_rr_injector;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int SC = 2;
    localparam int TO = 10;
    localparam int CW = 4;
    localparam int GW = $clog2(N);

    logic          clk;
    logic          rst_async;
    logic          enable;
    logic          err_clr;
    logic          busy;
    logic [GW-1:0] grant_id;
    logic          timeout_err;
    logic [CW-1:0] tx_count;

    int checks   = 0;
    int failures = 0;
    int last;
    int txc;

    twophase_rr_injector_if #(.N(N), .W(W)) b ();

    twophase_rr_injector #(
        .N(N), .W(W), .SETUP_CYC(SC), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_async(rst_async),
        .enable(enable),
        .err_clr(err_clr),
        .bus(b.slave),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_err(timeout_err),
        .tx_count(tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Winner = first valid requester after the previous winner, wrapping.
    function automatic int pick(input logic [N-1:0] m);
        for (int k = 1; k <= N; k++)
            if (m[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    task automatic start_tx(input logic [N-1:0] mask, input bit keep,
                            output int g, output logic [W-1:0] d,
                            output logic r0);
        logic [N*W-1:0] dat;
        int k;
        @(negedge clk);
        for (int i = 0; i < N; i++) dat[i*W +: W] = W'($urandom);
        b.in_valid = mask;
        b.in_data  = dat;
        g = pick(mask);
        d = dat[g*W +: W];
        #1;
        chk("in_ready", 32'(b.in_ready), 32'(1) << g);
        chk("busy_idle", 32'(busy), 32'(0));
        r0 = b.req_out;
        @(negedge clk);
        if (!keep) b.in_valid = '0;
        chk("in_ready_busy", 32'(b.in_ready), 32'(0));
        chk("data_out", 32'(b.data_out), 32'(d));
        chk("grant_id", 32'(grant_id), 32'(g));
        k = 0;
        while (b.req_out === r0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("setup_cyc", 32'(k), 32'(SC));
        chk("data_hold", 32'(b.data_out), 32'(d));
    endtask

    task automatic finish_tx(input int g, input logic [W-1:0] d,
                             input logic r0, input int dly);
        int k;
        repeat (dly) begin
            @(negedge clk);
            chk("wait_hold", 32'({b.req_out, b.data_out}), 32'({~r0, d}));
        end
        b.ack_in = b.req_out;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ack_lat", 32'(k), 32'(3));
        last = g;
        txc  = (txc + 1) % (1 << CW);
        chk("tx_count", 32'(tx_count), 32'(txc));
        chk("no_err", 32'(timeout_err), 32'(0));
    endtask

    task automatic run_tx(input logic [N-1:0] mask, input int dly);
        int g;
        logic [W-1:0] d;
        logic r0;
        start_tx(mask, 1'b0, g, d, r0);
        finish_tx(g, d, r0, dly);
    endtask

    task automatic check_reset();
        chk("rst_req", 32'(b.req_out), 32'(0));
        chk("rst_data", 32'(b.data_out), 32'(0));
        chk("rst_grant", 32'(grant_id), 32'(0));
        chk("rst_err", 32'(timeout_err), 32'(0));
        chk("rst_cnt", 32'(tx_count), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        int g, k;
        logic [W-1:0] d;
        logic r0;
        logic [N-1:0] m;
        rst_async  = 1'b1;
        enable     = 1'b1;
        err_clr    = 1'b0;
        b.in_valid = '0;
        b.in_data  = '0;
        b.ack_in   = 1'b0;
        last = N - 1;
        txc  = 0;
        repeat (2) @(negedge clk);
        check_reset();
        rst_async = 1'b0;

        run_tx(3'b001, 3);
        repeat (6) run_tx('1, 1);

        for (int i = 0; i < 20; i++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            run_tx(m, int'($urandom_range(0, 4)));
        end

        @(negedge clk);
        b.in_valid = '0;
        repeat (3) @(negedge clk);
        chk("idle_nov_rdy", 32'(b.in_ready), 32'(0));
        chk("idle_nov_busy", 32'(busy), 32'(0));

        // Sink never answers: watchdog must fire and hold the channel.
        start_tx('1, 1'b0, g, d, r0);
        k = 0;
        while (!timeout_err && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("to_lat", 32'(k), 32'(TO + 1));
        chk("to_hold", 32'({b.req_out, b.data_out}), 32'({~r0, d}));
        b.ack_in = b.req_out;
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(timeout_err), 32'(1));
        chk("err_busy", 32'(busy), 32'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", 32'(timeout_err), 32'(0));
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("late_ack_done", 32'(busy), 32'(0));
        last = g;
        txc  = (txc + 1) % (1 << CW);
        chk("to_count", 32'(tx_count), 32'(txc));

        // Drop enable mid-transaction with requests still pending.
        start_tx('1, 1'b1, g, d, r0);
        enable = 1'b0;
        finish_tx(g, d, r0, 2);
        repeat (4) begin
            @(negedge clk);
            chk("dis_rdy", 32'(b.in_ready), 32'(0));
            chk("dis_busy", 32'(busy), 32'(0));
        end
        b.in_valid = '0;
        enable = 1'b1;

        b.ack_in = ~b.req_out;
        repeat (5) @(negedge clk);
        chk("spur_busy", 32'(busy), 32'(0));
        chk("spur_cnt", 32'(tx_count), 32'(txc));
        b.ack_in = b.req_out;
        repeat (4) @(negedge clk);

        start_tx('1, 1'b0, g, d, r0);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        #($urandom_range(1, 8));
        rst_async = 1'b1;
        b.ack_in  = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        rst_async = 1'b0;
        last = N - 1;
        txc  = 0;

        for (int i = 0; i < 17; i++) run_tx('1, int'($urandom_range(0, 3)));
        chk("wrap17", 32'(tx_count), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
